// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: buffers decoded load/store ops, captures missing
// operands from the CDB and issues the head entry to the memory operator.
module mem_issue_queue #(
    parameter int DEPTH_LOG = 3,
    parameter int TAG_W     = 3
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_pipline,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    input  logic [TAG_W-1:0]     enq_ins_id,
    input  logic [6:0]           enq_opcode,
    input  logic [2:0]           enq_funct3,
    input  logic                 enq_rs1_rdy,
    input  logic [31:0]          enq_rs1_val,
    input  logic [TAG_W-1:0]     enq_rs1_tag,
    input  logic                 enq_rs2_rdy,
    input  logic [31:0]          enq_rs2_val,
    input  logic [TAG_W-1:0]     enq_rs2_tag,
    input  logic [31:0]          enq_imm,
    input  logic [31:0]          enq_pc,
    input  logic                 cdb_valid,
    input  logic [TAG_W-1:0]     cdb_tag,
    input  logic [31:0]          cdb_val,
    input  logic                 mem_busy,
    output logic                 have_ins,
    output logic [TAG_W-1:0]     ins_id,
    output logic [31:0]          rs1_val,
    output logic [31:0]          rs2_val,
    output logic [31:0]          imm_val,
    output logic [6:0]           opcode,
    output logic [2:0]           funct3,
    output logic [31:0]          request_PC,
    output logic [DEPTH_LOG:0]   occupancy
);

    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH_CNT = (DEPTH_LOG + 1)'(DEPTH);

    logic               r_valid   [DEPTH];
    logic [TAG_W-1:0]   r_id      [DEPTH];
    logic [6:0]         r_opcode  [DEPTH];
    logic [2:0]         r_funct3  [DEPTH];
    logic               r_rs1_rdy [DEPTH];
    logic [31:0]        r_rs1_val [DEPTH];
    logic [TAG_W-1:0]   r_rs1_tag [DEPTH];
    logic               r_rs2_rdy [DEPTH];
    logic [31:0]        r_rs2_val [DEPTH];
    logic [TAG_W-1:0]   r_rs2_tag [DEPTH];
    logic [31:0]        r_imm     [DEPTH];
    logic [31:0]        r_pc      [DEPTH];

    logic [DEPTH_LOG-1:0] r_head;
    logic [DEPTH_LOG-1:0] r_tail;
    logic [DEPTH_LOG:0]   r_count;
    logic                 r_issue_q;

    logic [TAG_W-1:0] r_ins_id;
    logic [31:0]      r_rs1_out;
    logic [31:0]      r_rs2_out;
    logic [31:0]      r_imm_out;
    logic [6:0]       r_opcode_out;
    logic [2:0]       r_funct3_out;
    logic [31:0]      r_pc_out;

    logic        w_enq_fire;
    logic        w_issue;
    logic        w_enq_rs1_rdy;
    logic [31:0] w_enq_rs1_val;
    logic        w_enq_rs2_rdy;
    logic [31:0] w_enq_rs2_val;

    // Issue uses only registered readiness, so a CDB wakeup of the head takes
    // effect one cycle later; the previous-issue gap lets the operator raise mem_busy.
    always_comb begin
        enq_ready     = (r_count < DEPTH_CNT);
        w_enq_fire    = enq_valid && enq_ready;
        w_issue       = (r_count != '0) && r_rs1_rdy[r_head] && r_rs2_rdy[r_head]
                        && !mem_busy && !r_issue_q;
        w_enq_rs1_rdy = enq_rs1_rdy || (cdb_valid && (cdb_tag == enq_rs1_tag));
        w_enq_rs1_val = enq_rs1_rdy ? enq_rs1_val : cdb_val;
        w_enq_rs2_rdy = enq_rs2_rdy || (cdb_valid && (cdb_tag == enq_rs2_tag));
        w_enq_rs2_val = enq_rs2_rdy ? enq_rs2_val : cdb_val;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_issue_q    <= 1'b0;
            r_ins_id     <= '0;
            r_rs1_out    <= '0;
            r_rs2_out    <= '0;
            r_imm_out    <= '0;
            r_opcode_out <= '0;
            r_funct3_out <= '0;
            r_pc_out     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (flush_pipline) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_issue_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (rdy_in) begin
            r_issue_q <= w_issue;

            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && cdb_valid) begin
                    if (!r_rs1_rdy[i] && (r_rs1_tag[i] == cdb_tag)) begin
                        r_rs1_rdy[i] <= 1'b1;
                        r_rs1_val[i] <= cdb_val;
                    end
                    if (!r_rs2_rdy[i] && (r_rs2_tag[i] == cdb_tag)) begin
                        r_rs2_rdy[i] <= 1'b1;
                        r_rs2_val[i] <= cdb_val;
                    end
                end
            end

            if (w_issue) begin
                r_ins_id        <= r_id[r_head];
                r_rs1_out       <= r_rs1_val[r_head];
                r_rs2_out       <= r_rs2_val[r_head];
                r_imm_out       <= r_imm[r_head];
                r_opcode_out    <= r_opcode[r_head];
                r_funct3_out    <= r_funct3[r_head];
                r_pc_out        <= r_pc[r_head];
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end

            // The tail slot is never valid here, so this write cannot collide with a wakeup.
            if (w_enq_fire) begin
                r_valid[r_tail]   <= 1'b1;
                r_id[r_tail]      <= enq_ins_id;
                r_opcode[r_tail]  <= enq_opcode;
                r_funct3[r_tail]  <= enq_funct3;
                r_rs1_rdy[r_tail] <= w_enq_rs1_rdy;
                r_rs1_val[r_tail] <= w_enq_rs1_val;
                r_rs1_tag[r_tail] <= enq_rs1_tag;
                r_rs2_rdy[r_tail] <= w_enq_rs2_rdy;
                r_rs2_val[r_tail] <= w_enq_rs2_val;
                r_rs2_tag[r_tail] <= enq_rs2_tag;
                r_imm[r_tail]     <= enq_imm;
                r_pc[r_tail]      <= enq_pc;
                r_tail            <= r_tail + 1'b1;
            end

            unique case ({w_enq_fire, w_issue})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        have_ins   = r_issue_q & rdy_in;
        ins_id     = r_ins_id;
        rs1_val    = r_rs1_out;
        rs2_val    = r_rs2_out;
        imm_val    = r_imm_out;
        opcode     = r_opcode_out;
        funct3     = r_funct3_out;
        request_PC = r_pc_out;
        occupancy  = r_count;
    end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Scoreboard bench for mem_issue_queue: a queue-level reference model predicts each
// issue; a negedge monitor compares every have_ins pulse and the per-cycle status.
module tb_mem_issue_queue;

    typedef struct {
        logic [2:0]  id;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        r1;
        logic [31:0] v1;
        logic [2:0]  t1;
        logic        r2;
        logic [31:0] v2;
        logic [2:0]  t2;
        logic [31:0] imm;
        logic [31:0] pc;
    } ent_t;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_pipline, enq_valid, enq_ready;
    logic [2:0]  enq_ins_id, enq_rs1_tag, enq_rs2_tag, cdb_tag;
    logic [6:0]  enq_opcode;
    logic [2:0]  enq_funct3;
    logic        enq_rs1_rdy, enq_rs2_rdy, cdb_valid, mem_busy, have_ins;
    logic [31:0] enq_rs1_val, enq_rs2_val, enq_imm, enq_pc, cdb_val;
    logic [2:0]  ins_id, funct3;
    logic [31:0] rs1_val, rs2_val, imm_val, request_PC;
    logic [6:0]  opcode;
    logic [3:0]  occupancy;

    int   total = 0;
    int   bad = 0;
    bit   checking = 0;
    bit   prevHave = 0;
    bit   pend = 0;
    ent_t q[$];
    ent_t expq[$];

    mem_issue_queue #(.DEPTH_LOG(3), .TAG_W(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipline(flush_pipline),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_ins_id(enq_ins_id),
        .enq_opcode(enq_opcode), .enq_funct3(enq_funct3),
        .enq_rs1_rdy(enq_rs1_rdy), .enq_rs1_val(enq_rs1_val), .enq_rs1_tag(enq_rs1_tag),
        .enq_rs2_rdy(enq_rs2_rdy), .enq_rs2_val(enq_rs2_val), .enq_rs2_tag(enq_rs2_tag),
        .enq_imm(enq_imm), .enq_pc(enq_pc),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .mem_busy(mem_busy),
        .have_ins(have_ins), .ins_id(ins_id), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .imm_val(imm_val), .opcode(opcode), .funct3(funct3), .request_PC(request_PC),
        .occupancy(occupancy)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Queue-level model of one clock edge, evaluated with the inputs the DUT samples.
    task automatic modelEdge();
        bit canIssue, accept;
        ent_t e;
        if (rst_in || flush_pipline) begin
            if (pend && !rdy_in && expq.size() > 0) void'(expq.pop_back());
            q.delete();
            pend = 0;
        end else if (rdy_in) begin
            canIssue = 0;
            if (q.size() > 0 && !mem_busy && !pend)
                canIssue = q[0].r1 && q[0].r2;
            accept = enq_valid && (q.size() < 8);
            if (cdb_valid) begin
                foreach (q[i]) begin
                    if (!q[i].r1 && q[i].t1 == cdb_tag) begin q[i].r1 = 1; q[i].v1 = cdb_val; end
                    if (!q[i].r2 && q[i].t2 == cdb_tag) begin q[i].r2 = 1; q[i].v2 = cdb_val; end
                end
            end
            if (canIssue) expq.push_back(q.pop_front());
            pend = canIssue;
            if (accept) begin
                e.id  = enq_ins_id;  e.opc = enq_opcode; e.f3 = enq_funct3;
                e.t1  = enq_rs1_tag; e.t2  = enq_rs2_tag;
                e.imm = enq_imm;     e.pc  = enq_pc;
                e.r1  = enq_rs1_rdy || (cdb_valid && cdb_tag == enq_rs1_tag);
                e.v1  = enq_rs1_rdy ? enq_rs1_val : cdb_val;
                e.r2  = enq_rs2_rdy || (cdb_valid && cdb_tag == enq_rs2_tag);
                e.v2  = enq_rs2_rdy ? enq_rs2_val : cdb_val;
                q.push_back(e);
            end
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk_in);
        modelEdge();
        #1;
    endtask

    task automatic setIdle();
        rst_in = 0; rdy_in = 1; flush_pipline = 0; enq_valid = 0; cdb_valid = 0; mem_busy = 0;
        enq_ins_id = 0; enq_opcode = 0; enq_funct3 = 0; enq_imm = 0; enq_pc = 0;
        enq_rs1_rdy = 1; enq_rs1_val = 0; enq_rs1_tag = 0;
        enq_rs2_rdy = 1; enq_rs2_val = 0; enq_rs2_tag = 0;
        cdb_tag = 0; cdb_val = 0;
    endtask

    task automatic setEnq(input logic [2:0] id, input logic [6:0] opc, input logic r1,
                          input logic [31:0] v1, input logic [2:0] t1, input logic r2,
                          input logic [31:0] v2, input logic [2:0] t2, input logic [31:0] imm);
        enq_valid = 1; enq_ins_id = id; enq_opcode = opc; enq_funct3 = 3'd2;
        enq_rs1_rdy = r1; enq_rs1_val = v1; enq_rs1_tag = t1;
        enq_rs2_rdy = r2; enq_rs2_val = v2; enq_rs2_tag = t2;
        enq_imm = imm; enq_pc = 32'h100 + {27'd0, id, 2'b00};
    endtask

    task automatic idle(input int n);
        setIdle();
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    // Monitor: status every cycle, full payload compare on every issue strobe.
    always @(negedge clk_in) begin
        ent_t e;
        if (checking) begin
            checkOutput("occupancy", 64'(occupancy), 64'(q.size()));
            checkOutput("enq_ready", 64'(enq_ready), 64'(q.size() < 8));
            checkOutput("have_ins", 64'(have_ins), 64'(pend && rdy_in));
            if (have_ins === 1'b1) begin
                checkOutput("issue_gap", 64'(prevHave), 64'(0));
                if (expq.size() == 0) begin
                    checkOutput("unexpected_issue", 64'(1), 64'(0));
                end else begin
                    e = expq.pop_front();
                    checkOutput("ins_id", 64'(ins_id), 64'(e.id));
                    checkOutput("rs1_val", 64'(rs1_val), 64'(e.v1));
                    checkOutput("rs2_val", 64'(rs2_val), 64'(e.v2));
                    checkOutput("imm_val", 64'(imm_val), 64'(e.imm));
                    checkOutput("opcode", 64'(opcode), 64'(e.opc));
                    checkOutput("funct3", 64'(funct3), 64'(e.f3));
                    checkOutput("request_PC", 64'(request_PC), 64'(e.pc));
                end
            end
            prevHave = (have_ins === 1'b1);
        end
    end

    initial begin
        int n;
        setIdle();
        rst_in = 1;
        applyStimulus();
        applyStimulus();
        checking = 1;
        checkOutput("rst_payload", {32'(ins_id), rs1_val}, 64'd0);
        checkOutput("rst_payload2", {rs2_val, imm_val}, 64'd0);
        checkOutput("rst_payload3", {25'd0, opcode, funct3, 29'd0} | 64'(request_PC), 64'd0);
        setIdle();

        // Single ready load issues two cycles after enqueue.
        setEnq(3'd2, 7'b0000011, 1, 32'h1000, 0, 1, 0, 0, 32'd4);
        applyStimulus();
        idle(4);

        // Store waits on tag 5; the CDB broadcast releases it.
        setEnq(3'd1, 7'b0100011, 1, 32'h2000, 0, 0, 0, 3'd5, 32'd8);
        applyStimulus();
        idle(3);
        cdb_valid = 1; cdb_tag = 3'd5; cdb_val = 32'hDEADBEEF;
        applyStimulus();
        idle(4);

        // Fill with a blocked head (younger entries ready), 9th enqueue dropped.
        for (int i = 0; i < 9; i++) begin
            setEnq(3'(i), 7'b0000011, (i != 0), 32'h3000 + 32'(i), 3'd6, 1, 32'(i), 0, 32'(i));
            applyStimulus();
        end
        idle(4);
        cdb_valid = 1; cdb_tag = 3'd6; cdb_val = 32'h0BAD_F00D;
        applyStimulus();
        idle(24);

        // Flush with a concurrent enqueue and CDB hit.
        for (int i = 0; i < 4; i++) begin
            setEnq(3'(i + 4), 7'b0100011, (i != 0), 32'h4000, 3'd7, 1, 32'h55, 0, 32'd0);
            applyStimulus();
        end
        setEnq(3'd3, 7'b0000011, 1, 32'h1, 0, 1, 0, 0, 0);
        flush_pipline = 1; cdb_valid = 1; cdb_tag = 3'd7; cdb_val = 32'h77;
        applyStimulus();
        idle(6);

        // Stall while the head is ready, then release.
        setEnq(3'd6, 7'b0000011, 1, 32'h6000, 0, 1, 0, 0, 32'd12);
        applyStimulus();
        setIdle();
        rdy_in = 0;
        for (int i = 0; i < 4; i++) applyStimulus();
        idle(5);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            setIdle();
            if ($urandom_range(0, 2) != 0)
                setEnq(3'($urandom), 7'($urandom), $urandom_range(0, 1) == 1, $urandom,
                       3'($urandom), $urandom_range(0, 1) == 1, $urandom, 3'($urandom), $urandom);
            enq_funct3    = 3'($urandom);
            enq_pc        = $urandom;
            cdb_valid     = $urandom_range(0, 1) == 1;
            cdb_tag       = 3'($urandom);
            cdb_val       = $urandom;
            mem_busy      = $urandom_range(0, 3) == 0;
            rdy_in        = $urandom_range(0, 7) != 0;
            flush_pipline = $urandom_range(0, 59) == 0;
            rst_in        = $urandom_range(0, 499) == 0;
            applyStimulus();
        end

        // Drain: cycle CDB tags so every waiting operand wakes.
        n = 0;
        while ((q.size() != 0 || expq.size() != 0 || pend) && n < 300) begin
            setIdle();
            cdb_valid = 1; cdb_tag = 3'(n); cdb_val = $urandom;
            applyStimulus();
            n++;
        end
        idle(3);
        checkOutput("drain", 64'(q.size() + expq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
